// File: rtl/pcs_10g_pkg.sv
// Shared 10G PCS definitions.
// - gb_state_e : TX gearbox controller state encoding (IDLE/WARM/RUN/FAULT).
// - GB_SEQ_N   : 64b/66b gearbox period in cycles (32 blocks -> 33 words),
//                shared with the gearbox datapath so both agree on the schedule.
package pcs_10g_pkg;

  localparam int unsigned GB_SEQ_N = 33;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWarm  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } gb_state_e;

endpackage

// File: rtl/pcs_10g_tx_gearbox_ctrl.sv
// 10G PCS TX gearbox sequencing controller.
// Brings the TX datapath up after the SERDES lane reports ready (fixed warm-up),
// then runs the gearbox period: one stall cycle per GB_SEQ_N cycles, during which
// the XGMII source and encoder/scrambler hold while the gearbox drains residual bits.
// Ports:
//   clk          : PCS TX clock
//   reset        : asynchronous active-high reset
//   en_i         : transmit enable (management)
//   serdes_rdy_i : SERDES TX lane ready
//   xgmii_rdy_o  : XGMII word accepted / encoder advance enable
//   gb_v_o       : gearbox output word valid
//   gb_seq_o     : gearbox sequence index (0 outside RUN)
//   state_o      : controller state (IDLE=0, WARM=1, RUN=2, FAULT=3)
//   err_o        : sticky lane-loss fault (cleared only by en_i low or reset)
module pcs_10g_tx_gearbox_ctrl #(
  parameter int unsigned GB_SEQ_N = pcs_10g_pkg::GB_SEQ_N,
  parameter int unsigned GB_SEQ_W = $clog2(GB_SEQ_N),
  parameter int unsigned WARM_N   = 16,
  parameter int unsigned WARM_W   = $clog2(WARM_N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                serdes_rdy_i,
  output logic                xgmii_rdy_o,
  output logic                gb_v_o,
  output logic [GB_SEQ_W-1:0] gb_seq_o,
  output logic [1:0]          state_o,
  output logic                err_o
);

  import pcs_10g_pkg::*;

  localparam logic [GB_SEQ_W-1:0] SeqLast  = GB_SEQ_W'(GB_SEQ_N - 1);
  localparam logic [WARM_W-1:0]   WarmLast = WARM_W'(WARM_N - 1);

  gb_state_e           state_q, state_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [GB_SEQ_W-1:0] seq_q, seq_d;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    seq_d      = seq_q;
    // en_i low overrides everything, including a simultaneous lane loss.
    if (!en_i) begin
      state_d    = StIdle;
      warm_cnt_d = '0;
      seq_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (serdes_rdy_i) begin
            state_d    = StWarm;
            warm_cnt_d = '0;
          end
        end
        StWarm: begin
          if (!serdes_rdy_i) begin
            state_d    = StIdle;
            warm_cnt_d = '0;
          end else if (warm_cnt_q == WarmLast) begin
            state_d = StRun;
            seq_d   = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!serdes_rdy_i) begin
            state_d = StFault;
          end else begin
            seq_d = (seq_q == SeqLast) ? '0 : seq_q + 1'b1;
          end
        end
        StFault: begin
          // Sticky: a returning lane does not clear the fault.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      warm_cnt_q <= '0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      seq_q      <= seq_d;
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  assign gb_v_o      = (state_q == StRun);
  assign xgmii_rdy_o = (state_q == StRun) && (seq_q != SeqLast);
  assign gb_seq_o    = (state_q == StRun) ? seq_q : '0;
  assign state_o     = state_q;
  assign err_o       = (state_q == StFault);

endmodule

// File: tb/tb_pcs_10g_tx_gearbox_ctrl.sv
module tb_pcs_10g_tx_gearbox_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic       serdes_rdy_i;
  logic       xgmii_rdy_o;
  logic       gb_v_o;
  logic [5:0] gb_seq_o;
  logic [1:0] state_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  pcs_10g_tx_gearbox_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_i),
    .serdes_rdy_i (serdes_rdy_i),
    .xgmii_rdy_o  (xgmii_rdy_o),
    .gb_v_o       (gb_v_o),
    .gb_seq_o     (gb_seq_o),
    .state_o      (state_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Advance one active edge, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; en_i = 1'b0; serdes_rdy_i = 1'b0;
    #2;
    checks++;
    if ({xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async outs=%b want 0", {xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release outs=%b want 0", {xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o});
    end
  endtask

  // Inputs applied between edges: next edge is edge 1; RUN from edge 17.
  task automatic test_bringup(input string tag);
    en_i = 1'b1; serdes_rdy_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (k < 17) begin
        if (state_o !== 2'd1 || xgmii_rdy_o !== 1'b0 || gb_v_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_warm edge=%0d state=%0d rdy=%b v=%b want state=1 rdy=0 v=0",
                   tag, k, state_o, xgmii_rdy_o, gb_v_o);
        end
      end else begin
        if (state_o !== 2'd2 || gb_seq_o !== 6'd0 || xgmii_rdy_o !== 1'b1 || gb_v_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_run edge=%0d state=%0d seq=%0d rdy=%b v=%b want 2/0/1/1",
                   tag, k, state_o, gb_seq_o, xgmii_rdy_o, gb_v_o);
        end
      end
    end
  endtask

  task automatic test_run_period();
    int accepts = 0;
    int stalls  = 0;
    for (int i = 0; i < 99; i++) begin
      checks++;
      if (gb_seq_o !== 6'(i % 33) || xgmii_rdy_o !== ((i % 33) != 32) || gb_v_o !== 1'b1) begin
        errors++;
        $display("FAIL run_period i=%0d seq=%0d rdy=%b v=%b want seq=%0d rdy=%b v=1",
                 i, gb_seq_o, xgmii_rdy_o, gb_v_o, i % 33, (i % 33) != 32);
      end
      if (xgmii_rdy_o === 1'b1) accepts++;
      else stalls++;
      tick();
    end
    checks++;
    if (accepts != 96 || stalls != 3) begin
      errors++;
      $display("FAIL run_accepts accepts=%0d stalls=%0d want 96/3", accepts, stalls);
    end
  endtask

  task automatic test_warm_drop();
    en_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL warm_drop_idle state=%0d want 0", state_o);
    end
    en_i = 1'b1; serdes_rdy_i = 1'b1;
    tick();     // WARM, warm_cnt=0
    repeat (10) tick();  // warm_cnt=10
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL warm_drop_at10 state=%0d want 1", state_o);
    end
    serdes_rdy_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL warm_drop_back state=%0d want 0", state_o);
    end
    test_bringup("rewarm");
  endtask

  task automatic test_fault();
    repeat (20) tick();
    checks++;
    if (gb_seq_o !== 6'd20 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL fault_pre seq=%0d state=%0d want 20/2", gb_seq_o, state_o);
    end
    serdes_rdy_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd3 || err_o !== 1'b1 || xgmii_rdy_o !== 1'b0 || gb_v_o !== 1'b0 ||
        gb_seq_o !== 6'd0) begin
      errors++;
      $display("FAIL fault_enter state=%0d err=%b rdy=%b v=%b seq=%0d want 3/1/0/0/0",
               state_o, err_o, xgmii_rdy_o, gb_v_o, gb_seq_o);
    end
    serdes_rdy_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_o !== 2'd3 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky state=%0d err=%b want 3/1", state_o, err_o);
    end
    en_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear state=%0d err=%b want 0/0", state_o, err_o);
    end
  endtask

  task automatic test_both_low();
    test_bringup("both");
    repeat (5) tick();
    en_i = 1'b0; serdes_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state_o !== 2'd0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL both_low i=%0d state=%0d err=%b want 0/0", i, state_o, err_o);
      end
    end
  endtask

  task automatic test_async_reset();
    test_bringup("prerst");
    repeat (15) tick();
    checks++;
    if (gb_seq_o !== 6'd15) begin
      errors++;
      $display("FAIL arst_pre seq=%0d want 15", gb_seq_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o} !== 11'd0) begin
      errors++;
      $display("FAIL arst_immediate outs=%b want 0", {xgmii_rdy_o, gb_v_o, gb_seq_o, state_o, err_o});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL arst_release state=%0d want 0", state_o);
    end
    @(negedge clk);
    // Requalify from IDLE: edge after this sample is edge 1 with full warm-up.
    en_i = 1'b0;
    tick();
    test_bringup("postrst");
  endtask

  initial begin
    test_reset();
    test_bringup("bringup");
    test_run_period();
    test_warm_drop();
    test_fault();
    test_both_low();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcs_10g_tx_gearbox_ctrl.md
# pcs_10g_tx_gearbox_ctrl

Sequencing controller for the 10G PCS transmit path. It brings the TX datapath up once the SERDES lane is ready, then runs the 33-cycle gearbox schedule. In each period, 32 66-bit blocks are packed into 33 64-bit SERDES words. The block stalls the XGMII source and the encoder/scrambler for one cycle per period, and drives the gearbox with its bit-offset sequence index. It sits beside the PCS TX encoder, between the MAC-side XGMII interface and the gearbox/SERDES.

## Interface
Parameters:
- GB_SEQ_N, 33: gearbox period in cycles; cycles GB_SEQ_N-1 of each period is the stall cycle.
- GB_SEQ_W, $clog2(GB_SEQ_N): width of the sequence index.
- WARM_N, 16: number of warm-up cycles between SERDES ready and RUN.
- WARM_W, $clog2(WARM_N): width of the warm-up counter.

Ports:
- clk  in  1  PCS TX clock.
- reset  in  1  asynchronous, active-high reset.
- en_i  in  1  transmit enable (management).
- serdes_rdy_i  in  1  SERDES TX lane ready.
- xgmii_rdy_o  out  1  XGMII word accepted this cycle; when low, MAC holds txd/txc and the encoder/scrambler do not advance.
- gb_v_o  out  1  gearbox output word valid toward SERDES.
- gb_seq_o  out  GB_SEQ_W  gearbox sequence index, 0..GB_SEQ_N-1.
- state_o  out  2  controller state: IDLE=0, WARM=1, RUN=2, FAULT=3.
- err_o  out  1  lane-loss fault, sticky.

## Operation
- Registers: state (2b), warm_cnt (WARM_W), seq (GB_SEQ_W). All outputs are decodes of these registers only; there is no input-to-output combinational path.
- Decodes:
  - xgmii_rdy_o = (state==RUN) && (seq != GB_SEQ_N-1).
  - gb_v_o = (state==RUN).
  - gb_seq_o = seq in RUN, else 0.
  - err_o = (state==FAULT).
- Transitions, evaluated in priority order each cycle:
  - en_i low, any state -> IDLE; warm_cnt=0, seq=0.
  - IDLE: serdes_rdy_i high -> WARM, warm_cnt=0.
  - WARM: serdes_rdy_i low -> IDLE, warm_cnt=0. Else, if warm_cnt==WARM_N-1 -> RUN, seq=0. Otherwise warm_cnt+1.
  - RUN: serdes_rdy_i low -> FAULT. Otherwise seq = (seq==GB_SEQ_N-1) ? 0 : seq+1.
  - FAULT: hold. Exit only through en_i low (-> IDLE). serdes_rdy_i returning high does not clear FAULT.
- Arithmetic: seq wraps exactly at GB_SEQ_N-1 -> 0 and never reaches GB_SEQ_N. warm_cnt never exceeds WARM_N-1.

## Timing
- Reset (async assert, sampled release): state=IDLE, warm_cnt=0, seq=0. Outputs: xgmii_rdy_o=0, gb_v_o=0, gb_seq_o=0, state_o=0, err_o=0.
- Bring-up latency: en_i and serdes_rdy_i are sampled high at edge t (state IDLE).
  - From edge t+1: WARM.
  - From edge t+1+WARM_N: RUN, with seq=0 and xgmii_rdy_o=1.
- RUN steady state, per 33 cycles:
  - xgmii_rdy_o high for 32 cycles and low for 1 (seq=32).
  - gb_v_o high for all 33 cycles.
- Stall cycle: the encoder/scrambler pipeline must hold its state at seq=32. The gearbox uses that cycle to emit its buffered residual bits.
- Lane loss in RUN: serdes_rdy_i sampled low at edge t gives FAULT from t+1. xgmii_rdy_o, gb_v_o and gb_seq_o drop to 0 in the same cycle, with no partial period.
- Reset asserted mid-period: all outputs return to their reset values immediately (asynchronous). After release, bring-up restarts from IDLE with a full WARM_N warm-up.
- en_i low and serdes_rdy_i low in the same cycle: en_i wins, so the next state is IDLE, not FAULT.

## Structure
- Shared package pcs_10g_pkg gains:
  - a state enum (IDLE/WARM/RUN/FAULT, 2b);
  - GB_SEQ_N=33 as the 64b/66b gearbox period constant, so the gearbox datapath uses the same value.
- No sub-module is needed. Two counters and a 4-state FSM sit in a single module.
- The gearbox datapath module consumes gb_seq_o and gb_v_o. The encoder/scrambler use xgmii_rdy_o as their advance enable.

## Test plan
- Reset then en_i=1, serdes_rdy_i=1 at edge 0, WARM_N=16 -> state_o=1 from edge 1; state_o=2, gb_seq_o=0, xgmii_rdy_o=1 from edge 17.
- RUN for 99 cycles -> xgmii_rdy_o low exactly at seq=32 (3 times), 96 accepts; gb_seq_o sequence 0..32,0..32,0..32; gb_v_o constantly 1.
- serdes_rdy_i drops at WARM warm_cnt=10 -> IDLE next cycle. Restoring it -> a full 16-cycle warm-up again before RUN.
- serdes_rdy_i drops at RUN seq=20 -> FAULT, err_o=1, xgmii_rdy_o=0. serdes_rdy_i back high -> stays FAULT. en_i low -> IDLE, err_o=0.
- en_i and serdes_rdy_i both go low in the same RUN cycle -> IDLE, err_o never asserts.
- Async reset asserted mid-cycle at RUN seq=15 -> outputs go to 0 before the next edge; after release, RUN is reached 17 edges after requalification.
